// File: rtl/viterbi_frame_ctrl_if.sv
// Purpose : bundles the upstream word handshake, decoder-core feed and decoded-byte tags of viterbi_frame_ctrl.
// Latency : n/a (wiring only).
// Backpressure: in_ready is the only stall; the core side and output tags are never back-pressured.
//
// master : controller side (consumes in_*, drives everything else).
// slave  : environment side (drives in_*, observes everything else).
interface viterbi_frame_ctrl_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        core_valid;
    logic [15:0] core_data;
    logic [2:0]  data_id;
    logic        pm_clear;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        busy;
    logic [15:0] frames_done;

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready, core_valid, core_data, data_id, pm_clear,
        output out_valid, out_sof, out_eof, busy, frames_done
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready, core_valid, core_data, data_id, pm_clear,
        input  out_valid, out_sof, out_eof, busy, frames_done
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Purpose : frame sequencer for the pipelined Viterbi core; forwards words, appends zero tail words, tags decoded bytes.
// Latency : accepted word -> core_valid 1 cycle; core_valid -> tagged output byte PIPE_LAT cycles.
// Backpressure: in_ready drops from frame end until the tail words have left the core pipeline.
//
// Ports: clk, rst (async, active-low); bus (master modport) carries in_valid/in_data/in_last/in_ready,
//        core_valid/core_data/data_id/pm_clear, out_valid/out_sof/out_eof, busy, frames_done.
module viterbi_frame_ctrl #(
    parameter int FRAME_WORDS = 64,
    parameter int TAIL_WORDS  = 1,
    parameter int PIPE_LAT    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    viterbi_frame_ctrl_if.master   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [7:0]          wcnt;
    logic [7:0]          wcnt_nxt;
    logic [2:0]          tcnt;
    logic                cur_data;
    logic                cur_eof;
    logic [PIPE_LAT-1:0] live_sr;
    logic [PIPE_LAT-1:0] data_sr;
    logic [PIPE_LAT-1:0] sof_sr;
    logic [PIPE_LAT-1:0] eof_sr;
    logic                accept;
    logic                first_word;
    logic                frame_end;
    logic                tail_done;
    logic                pipe_idle;

    assign accept     = bus.in_valid & bus.in_ready;
    assign first_word = (state == S_IDLE);
    assign wcnt_nxt   = first_word ? 8'd1 : wcnt + 8'd1;
    assign frame_end  = bus.in_last | (wcnt_nxt == 8'(FRAME_WORDS));
    assign tail_done  = (tcnt == 3'(TAIL_WORDS - 1));
    // Leave DRAIN one cycle early: when only the final stage is live and nothing
    // enters, the pipeline is empty by the time IDLE is visible.
    assign pipe_idle  = ~(|live_sr[PIPE_LAT-2:0]) & ~bus.core_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_RUN: if (accept) state_nxt = frame_end ? S_FLUSH : S_RUN;
            S_FLUSH:       if (tail_done) state_nxt = S_DRAIN;
            S_DRAIN:       if (pipe_idle) state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            wcnt            <= '0;
            tcnt            <= '0;
            cur_data        <= 1'b0;
            cur_eof         <= 1'b0;
            live_sr         <= '0;
            data_sr         <= '0;
            sof_sr          <= '0;
            eof_sr          <= '0;
            bus.in_ready    <= 1'b0;
            bus.core_valid  <= 1'b0;
            bus.core_data   <= '0;
            bus.data_id     <= '0;
            bus.pm_clear    <= 1'b0;
            bus.frames_done <= '0;
        end else begin
            state <= state_nxt;
            // Registered so in_ready stays low while reset is held.
            bus.in_ready   <= (state_nxt == S_IDLE) | (state_nxt == S_RUN);
            bus.core_valid <= accept | (state == S_FLUSH);
            bus.pm_clear   <= accept & first_word;
            cur_data       <= accept;
            cur_eof        <= accept & frame_end;

            if (accept) begin
                wcnt          <= wcnt_nxt;
                bus.core_data <= bus.in_data;
            end else if (state == S_FLUSH) begin
                bus.core_data <= '0;
            end

            if (accept & first_word)
                bus.data_id <= '0;
            else if (accept | (state == S_FLUSH))
                bus.data_id <= bus.data_id + 3'd1;

            if (state == S_FLUSH)
                tcnt <= tail_done ? 3'd0 : tcnt + 3'd1;

            // Tags ride alongside the core pipeline; stage 0 captures the current core word.
            live_sr <= {live_sr[PIPE_LAT-2:0], bus.core_valid};
            data_sr <= {data_sr[PIPE_LAT-2:0], cur_data};
            sof_sr  <= {sof_sr[PIPE_LAT-2:0],  bus.pm_clear};
            eof_sr  <= {eof_sr[PIPE_LAT-2:0],  cur_eof};

            if (bus.out_eof)
                bus.frames_done <= bus.frames_done + 16'd1;
        end
    end

    assign bus.out_valid = live_sr[PIPE_LAT-1] & data_sr[PIPE_LAT-1];
    assign bus.out_sof   = sof_sr[PIPE_LAT-1] & bus.out_valid;
    assign bus.out_eof   = eof_sr[PIPE_LAT-1] & bus.out_valid;
    assign bus.busy      = (state != S_IDLE) | (|live_sr);
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Purpose : randomized bench for viterbi_frame_ctrl against a timeline model of frames, tails and tags.
// Latency : model schedules core words at accept+1 and tags at core+PIPE_LAT.
// Backpressure: model predicts in_ready from frame-end timing; in_valid is random, including during flush/drain.
module tb_viterbi_frame_ctrl;
    localparam int FW = 9;
    localparam int TW = 3;
    localparam int PL = 10;
    localparam int NC = 512;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viterbi_frame_ctrl_if vif();

    viterbi_frame_ctrl #(
        .FRAME_WORDS(FW),
        .TAIL_WORDS (TW),
        .PIPE_LAT   (PL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -1;

    // Expected-event timeline for the current reset segment, indexed by cycle.
    logic        e_cv  [NC];
    logic [15:0] e_cd  [NC];
    logic [2:0]  e_id  [NC];
    logic        e_pm  [NC];
    logic        e_ov  [NC];
    logic        e_sof [NC];
    logic        e_eof [NC];
    logic        e_fd  [NC];

    logic        open;
    int          wcnt;
    logic [2:0]  nid;
    logic [2:0]  last_id;
    logic [15:0] last_cd;
    logic [15:0] fd;
    int          ready_from;
    int          busy_until;
    int          len;
    int          pct;
    logic        vld;
    logic        first;
    logic        fend;
    logic        exp_ready;
    logic        exp_busy;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_all_zero();
        chk_eq("rst_in_ready",    32'(vif.in_ready),    32'd0);
        chk_eq("rst_core_valid",  32'(vif.core_valid),  32'd0);
        chk_eq("rst_core_data",   32'(vif.core_data),   32'd0);
        chk_eq("rst_data_id",     32'(vif.data_id),     32'd0);
        chk_eq("rst_pm_clear",    32'(vif.pm_clear),    32'd0);
        chk_eq("rst_out_valid",   32'(vif.out_valid),   32'd0);
        chk_eq("rst_out_sof",     32'(vif.out_sof),     32'd0);
        chk_eq("rst_out_eof",     32'(vif.out_eof),     32'd0);
        chk_eq("rst_busy",        32'(vif.busy),        32'd0);
        chk_eq("rst_frames_done", 32'(vif.frames_done), 32'd0);
    endtask

    initial begin
        vif.in_valid = 1'b0;
        vif.in_data  = '0;
        vif.in_last  = 1'b0;

        for (int seg = 0; seg < 6; seg++) begin
            // Reset lands wherever the previous segment stopped, often mid-frame.
            @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            cyc = -1;
            chk_all_zero();
            for (int i = 0; i < NC; i++) begin
                e_cv[i] = 1'b0;  e_cd[i] = '0;    e_id[i] = '0;    e_pm[i] = 1'b0;
                e_ov[i] = 1'b0;  e_sof[i] = 1'b0; e_eof[i] = 1'b0; e_fd[i] = 1'b0;
            end
            open = 1'b0; wcnt = 0; nid = '0; last_id = '0; last_cd = '0; fd = '0;
            ready_from = 0; busy_until = -1;
            pct = (seg % 3 == 0) ? 100 : ((seg % 3 == 1) ? 60 : 30);
            len = int'($urandom_range(400, 150));
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;

            for (int c = 0; c < len; c++) begin
                cyc = c;
                exp_ready = (c >= ready_from);
                exp_busy  = open || (c <= busy_until);
                if (e_fd[c]) fd = fd + 16'd1;
                if (e_cv[c]) begin
                    last_id = e_id[c];
                    last_cd = e_cd[c];
                end
                chk_eq("in_ready",    32'(vif.in_ready),    32'(exp_ready));
                chk_eq("core_valid",  32'(vif.core_valid),  32'(e_cv[c]));
                chk_eq("core_data",   32'(vif.core_data),   32'(last_cd));
                chk_eq("data_id",     32'(vif.data_id),     32'(last_id));
                chk_eq("pm_clear",    32'(vif.pm_clear),    32'(e_pm[c]));
                chk_eq("out_valid",   32'(vif.out_valid),   32'(e_ov[c]));
                chk_eq("out_sof",     32'(vif.out_sof),     32'(e_sof[c]));
                chk_eq("out_eof",     32'(vif.out_eof),     32'(e_eof[c]));
                chk_eq("busy",        32'(vif.busy),        32'(exp_busy));
                chk_eq("frames_done", 32'(vif.frames_done), 32'(fd));

                vld = (int'($urandom_range(99, 0)) < pct);
                vif.in_valid = vld;
                vif.in_data  = 16'($urandom);
                vif.in_last  = ($urandom_range(7, 0) == 0);

                if (vld && exp_ready) begin
                    first = !open;
                    if (first) begin
                        open = 1'b1;
                        wcnt = 0;
                        nid  = '0;
                    end
                    wcnt++;
                    fend = vif.in_last || (wcnt == FW);
                    e_cv[c+1] = 1'b1;
                    e_cd[c+1] = vif.in_data;
                    e_id[c+1] = nid;
                    e_pm[c+1] = first;
                    nid = nid + 3'd1;
                    e_ov[c+1+PL]  = 1'b1;
                    e_sof[c+1+PL] = first;
                    e_eof[c+1+PL] = fend;
                    if (fend) begin
                        e_fd[c+2+PL] = 1'b1;
                        for (int t = 0; t < TW; t++) begin
                            e_cv[c+2+t] = 1'b1;
                            e_cd[c+2+t] = '0;
                            e_id[c+2+t] = nid;
                            nid = nid + 3'd1;
                        end
                        open       = 1'b0;
                        busy_until = c + 1 + TW + PL;
                        ready_from = c + 2 + TW + PL;
                    end
                end

                @(posedge clk);
                #1;
            end
        end

        rst = 1'b0;
        #1;
        cyc = -1;
        chk_all_zero();
        vif.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
